// File: rtl/ddr2_idelay_rst_seq_if.sv
// Sequencer-side signal bundle: DCM lock and IDELAYCTRL RDY in,
// IDELAYCTRL reset, PHY init reset and sequencer status out.
interface ddr2_idelay_rst_seq_if;
   logic       dcm_locked;
   logic       idelay_ctrl_rdy;
   logic       idelay_rst;
   logic       phy_init_rst;
   logic       seq_done;
   logic       seq_fail;
   logic [1:0] retry_cnt;

   modport master (
      input  dcm_locked,
      input  idelay_ctrl_rdy,
      output idelay_rst,
      output phy_init_rst,
      output seq_done,
      output seq_fail,
      output retry_cnt
   );

   modport slave (
      output dcm_locked,
      output idelay_ctrl_rdy,
      input  idelay_rst,
      input  phy_init_rst,
      input  seq_done,
      input  seq_fail,
      input  retry_cnt
   );
endinterface

// File: rtl/ddr2_idelay_rst_seq.sv
// IDELAYCTRL bring-up sequencer in the clk200 domain: lock qualify,
// reset pulse, RDY qualify with timeout/retry, PHY init reset hold.
module ddr2_idelay_rst_seq #(
   parameter int unsigned LOCK_STABLE_CYC = 64,
   parameter int unsigned RST_PULSE_CYC   = 16,
   parameter int unsigned RDY_STABLE_CYC  = 32,
   parameter int unsigned RDY_TIMEOUT_CYC = 4096,
   parameter int unsigned MAX_RETRY       = 3
) (
   input logic                   clk200,
   input logic                   rst200,
   ddr2_idelay_rst_seq_if.master bus
);

   function automatic int unsigned max2(int unsigned a, int unsigned b);
      return (a > b) ? a : b;
   endfunction

   localparam int unsigned MAXP =
      max2(max2(LOCK_STABLE_CYC, RST_PULSE_CYC),
           max2(RDY_STABLE_CYC, RDY_TIMEOUT_CYC));
   localparam int CW = $clog2(MAXP) + 1;

   localparam logic [CW-1:0] LOCK_END  = CW'(LOCK_STABLE_CYC - 1);
   localparam logic [CW-1:0] PULSE_END = CW'(RST_PULSE_CYC - 1);
   localparam logic [CW-1:0] STAB_END  = CW'(RDY_STABLE_CYC - 1);
   localparam logic [CW-1:0] TO_END    = CW'(RDY_TIMEOUT_CYC - 1);
   localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_WAIT_LOCK,
      S_RST_PULSE,
      S_WAIT_RDY,
      S_RDY_STABLE,
      S_DONE,
      S_FAIL
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [1:0]    retry, retry_nx;
   logic          lock_m, lock_s;
   logic          rdy;
   logic          irst_q, prst_q, done_q, fail_q;

   assign rdy = bus.idelay_ctrl_rdy;

   always_ff @(posedge clk200) begin
      if (rst200) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= bus.dcm_locked;
         lock_s <= lock_m;
      end
   end

   always_comb begin
      state_nx = state;
      retry_nx = retry;
      cnt_nx   = cnt + 1'b1;
      // lock loss outranks everything short of a latched failure
      if (state != S_FAIL && !lock_s) begin
         state_nx = S_WAIT_LOCK;
         retry_nx = 2'd0;
      end else begin
         unique case (state)
            S_WAIT_LOCK: begin
               if (cnt == LOCK_END) state_nx = S_RST_PULSE;
            end
            S_RST_PULSE: begin
               if (cnt == PULSE_END) state_nx = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
               if (rdy) begin
                  state_nx = S_RDY_STABLE;
               end else if (cnt == TO_END) begin
                  if (retry < RETRY_MAX) begin
                     retry_nx = retry + 2'd1;
                     state_nx = S_RST_PULSE;
                  end else begin
                     state_nx = S_FAIL;
                  end
               end
            end
            S_RDY_STABLE: begin
               if (!rdy) state_nx = S_WAIT_RDY;
               else if (cnt == STAB_END) state_nx = S_DONE;
            end
            S_DONE: begin
               if (!rdy) begin
                  if (retry < RETRY_MAX) begin
                     retry_nx = retry + 2'd1;
                     state_nx = S_RST_PULSE;
                  end else begin
                     state_nx = S_FAIL;
                  end
               end
            end
            S_FAIL: begin
               state_nx = S_FAIL;
            end
            default: state_nx = S_WAIT_LOCK;
         endcase
      end
      if (state_nx != state || !lock_s) cnt_nx = '0;
      else if (state == S_FAIL) cnt_nx = cnt;
   end

   always_ff @(posedge clk200) begin
      if (rst200) begin
         state  <= S_WAIT_LOCK;
         cnt    <= '0;
         retry  <= 2'd0;
         irst_q <= 1'b1;
         prst_q <= 1'b1;
         done_q <= 1'b0;
         fail_q <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         retry  <= retry_nx;
         irst_q <= (state_nx == S_WAIT_LOCK) ||
                   (state_nx == S_RST_PULSE) ||
                   (state_nx == S_FAIL);
         prst_q <= (state_nx != S_DONE);
         done_q <= (state_nx == S_DONE);
         fail_q <= (state_nx == S_FAIL);
      end
   end

   assign bus.idelay_rst   = irst_q;
   assign bus.phy_init_rst = prst_q;
   assign bus.seq_done     = done_q;
   assign bus.seq_fail     = fail_q;
   assign bus.retry_cnt    = retry;

endmodule

// File: tb/tb_ddr2_idelay_rst_seq.sv
// Bench for ddr2_idelay_rst_seq: directed bring-up scenarios plus
// random lock/rdy traffic against an elapsed-time reference model.
module tb_ddr2_idelay_rst_seq;

   localparam int LOCK_N = 64;
   localparam int PULSE_N = 16;
   localparam int STAB_N = 32;
   localparam int TO_N = 100;
   localparam int RMAX = 3;

   localparam int P_LOCK = 0;
   localparam int P_PULSE = 1;
   localparam int P_WRDY = 2;
   localparam int P_STAB = 3;
   localparam int P_DONE = 4;
   localparam int P_FAIL = 5;

   logic clk = 1'b0;
   logic rst200 = 1'b1;
   int   checks = 0;
   int   failures = 0;

   ddr2_idelay_rst_seq_if bus ();

   ddr2_idelay_rst_seq #(
      .LOCK_STABLE_CYC(LOCK_N),
      .RST_PULSE_CYC  (PULSE_N),
      .RDY_STABLE_CYC (STAB_N),
      .RDY_TIMEOUT_CYC(TO_N),
      .MAX_RETRY      (RMAX)
   ) dut (
      .clk200(clk),
      .rst200(rst200),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: phase plus entry time; durations from edge-count arithmetic.
   int   m_ph = P_LOCK;
   int   m_t0 = 0;
   int   m_z = 0;
   int   m_ret = 0;
   int   m_n = 0;
   logic m_l1 = 1'b0;
   logic m_l2 = 1'b0;
   logic m_ok = 1'b0;

   always @(posedge clk) begin : model
      int ph;
      int t0;
      int z;
      int ret;
      logic rdy;
      ph = m_ph;
      t0 = m_t0;
      z = m_z;
      ret = m_ret;
      rdy = bus.idelay_ctrl_rdy;
      if (rst200) begin
         ph = P_LOCK;
         t0 = m_n;
         z = m_n;
         ret = 0;
      end else if (m_ok) begin
         if (ph != P_FAIL && !m_l2) begin
            ph = P_LOCK;
            t0 = m_n;
            z = m_n;
            ret = 0;
         end else begin
            case (ph)
               P_LOCK: if (m_n - z == LOCK_N) begin
                  ph = P_PULSE;
                  t0 = m_n;
               end
               P_PULSE: if (m_n - t0 == PULSE_N) begin
                  ph = P_WRDY;
                  t0 = m_n;
               end
               P_WRDY: begin
                  if (rdy) begin
                     ph = P_STAB;
                     t0 = m_n;
                  end else if (m_n - t0 == TO_N) begin
                     ph = (ret < RMAX) ? P_PULSE : P_FAIL;
                     if (ret < RMAX) ret = ret + 1;
                     t0 = m_n;
                  end
               end
               P_STAB: begin
                  if (!rdy) begin
                     ph = P_WRDY;
                     t0 = m_n;
                  end else if (m_n - t0 == STAB_N) begin
                     ph = P_DONE;
                     t0 = m_n;
                  end
               end
               P_DONE: if (!rdy) begin
                  ph = (ret < RMAX) ? P_PULSE : P_FAIL;
                  if (ret < RMAX) ret = ret + 1;
                  t0 = m_n;
               end
               default: ;
            endcase
         end
      end
      m_l1 <= rst200 ? 1'b0 : bus.dcm_locked;
      m_l2 <= rst200 ? 1'b0 : m_l1;
      m_ok <= m_ok | rst200;
      m_n <= m_n + 1;
      m_ph <= ph;
      m_t0 <= t0;
      m_z <= z;
      m_ret <= ret;
   end

   always @(negedge clk) begin : compare
      logic [5:0] got;
      logic [5:0] exp;
      if (m_ok) begin
         got = {bus.idelay_rst, bus.phy_init_rst, bus.seq_done,
                bus.seq_fail, bus.retry_cnt};
         exp = {(m_ph == P_LOCK || m_ph == P_PULSE || m_ph == P_FAIL),
                (m_ph != P_DONE), (m_ph == P_DONE), (m_ph == P_FAIL),
                2'(m_ret)};
         chk("model", int'(got), int'(exp));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst200 = 1'b1;
      bus.dcm_locked = 1'b0;
      bus.idelay_ctrl_rdy = 1'b0;
      tick();
      tick();
      rst200 = 1'b0;
   endtask

   // Ticks until the selected output equals val; returns edges taken.
   task automatic wait_for(input int sel, input logic val,
                           input int bound, output int n);
      logic s;
      n = 0;
      do begin
         tick();
         n++;
         case (sel)
            0: s = bus.idelay_rst;
            1: s = bus.seq_done;
            default: s = bus.seq_fail;
         endcase
      end while (s != val && n < bound);
   endtask

   int n;

   initial begin
      bus.dcm_locked = 1'b0;
      bus.idelay_ctrl_rdy = 1'b0;
      do_reset();
      chk("rst_irst", bus.idelay_rst, 1);
      chk("rst_prst", bus.phy_init_rst, 1);
      chk("rst_done", bus.seq_done, 0);
      chk("rst_fail", bus.seq_fail, 0);
      chk("rst_retry", bus.retry_cnt, 0);

      // clean bring-up
      bus.dcm_locked = 1'b1;
      wait_for(0, 1'b0, 300, n);
      chk("s1_irst_fall", n, 82);
      repeat (20) tick();
      bus.idelay_ctrl_rdy = 1'b1;
      wait_for(1, 1'b1, 200, n);
      // one edge to first sample rdy, then 32 qualifying edges
      chk("s1_done_lat", n, 33);
      chk("s1_prst", bus.phy_init_rst, 0);
      chk("s1_retry", bus.retry_cnt, 0);

      // loss of rdy while done
      bus.idelay_ctrl_rdy = 1'b0;
      tick();
      chk("s5_done_clr", bus.seq_done, 0);
      chk("s5_prst", bus.phy_init_rst, 1);
      chk("s5_retry", bus.retry_cnt, 1);
      wait_for(0, 1'b0, 100, n);
      chk("s5_pulse_w", n, 16);
      bus.idelay_ctrl_rdy = 1'b1;
      wait_for(1, 1'b1, 200, n);
      chk("s5_redone", n, 33);
      bus.dcm_locked = 1'b0;
      wait_for(1, 1'b0, 20, n);
      chk("s5_lock_lat", n, 3);
      chk("s5_lock_retry", bus.retry_cnt, 0);
      chk("s5_lock_irst", bus.idelay_rst, 1);

      // lock glitch around count 40
      do_reset();
      bus.dcm_locked = 1'b1;
      repeat (42) tick();
      bus.dcm_locked = 1'b0;
      tick();
      bus.dcm_locked = 1'b1;
      chk("s2_irst_hold", bus.idelay_rst, 1);
      wait_for(0, 1'b0, 300, n);
      chk("s2_irst_fall", n, 82);

      // timeout / retry / fail
      do_reset();
      bus.dcm_locked = 1'b1;
      wait_for(0, 1'b0, 300, n);
      chk("s3_first_fall", n, 82);
      for (int r = 1; r <= RMAX; r++) begin
         wait_for(0, 1'b1, 300, n);
         chk("s3_timeout", n, TO_N);
         chk("s3_retry", bus.retry_cnt, r);
         wait_for(0, 1'b0, 100, n);
         chk("s3_pulse_w", n, PULSE_N);
      end
      wait_for(2, 1'b1, 300, n);
      chk("s3_fail_lat", n, TO_N);
      chk("s3_fail_retry", bus.retry_cnt, RMAX);
      bus.dcm_locked = 1'b0;
      repeat (10) tick();
      bus.idelay_ctrl_rdy = 1'b1;
      bus.dcm_locked = 1'b1;
      repeat (60) tick();
      chk("s3_sticky", bus.seq_fail, 1);
      do_reset();
      chk("s3_rst_clr", bus.seq_fail, 0);

      // rdy bounce
      bus.dcm_locked = 1'b1;
      wait_for(0, 1'b0, 300, n);
      bus.idelay_ctrl_rdy = 1'b1;
      repeat (10) tick();
      bus.idelay_ctrl_rdy = 1'b0;
      tick();
      chk("s4_no_done", bus.seq_done, 0);
      bus.idelay_ctrl_rdy = 1'b1;
      wait_for(1, 1'b1, 200, n);
      chk("s4_done_lat", n, 33);

      // reset mid-pulse
      do_reset();
      bus.dcm_locked = 1'b1;
      repeat (70) tick();
      chk("s6_in_pulse", bus.idelay_rst, 1);
      rst200 = 1'b1;
      tick();
      chk("s6_irst", bus.idelay_rst, 1);
      chk("s6_prst", bus.phy_init_rst, 1);
      chk("s6_done", bus.seq_done, 0);
      chk("s6_retry", bus.retry_cnt, 0);
      rst200 = 1'b0;
      wait_for(0, 1'b0, 300, n);
      chk("s6_refall", n, 82);

      // random lock/rdy traffic, model checks every cycle
      for (int s = 0; s < 120; s++) begin
         int   len;
         logic lk;
         logic rv;
         len = $urandom_range(1, 200);
         lk = ($urandom_range(0, 9) != 0);
         rv = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 29) == 0) begin
            rst200 = 1'b1;
            tick();
            rst200 = 1'b0;
         end
         bus.dcm_locked = lk;
         for (int c = 0; c < len; c++) begin
            bus.idelay_ctrl_rdy = rv ^ ($urandom_range(0, 63) == 0);
            tick();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
